// File: rtl/event_blinker_pkg.sv
// Shared state encoding and default timing constants for the event blinker.
// The default thresholds match the debouncer timing defaults (100 ms at 50 MHz).
package event_blinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEFAULT_ON_CLOCK_THR  = 5000000;
  localparam int DEFAULT_OFF_CLOCK_THR = 5000000;
  localparam int DEFAULT_MAX_PENDING   = 7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/event_blinker_sat_counter.sv
// Saturating up/down counter that holds the number of queued blink events.
// Built only when EVENT_BLINKER_QUEUE_EN is defined.
`ifdef EVENT_BLINKER_QUEUE_EN
module sat_updown_counter
  import event_blinker_pkg::*;
#(
  parameter int MAX_VAL = DEFAULT_MAX_PENDING,
  parameter int WIDTH   = $clog2(MAX_VAL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             sat_hit
);

  logic at_max;
  logic at_zero;

  assign at_max  = (count == WIDTH'(MAX_VAL));
  assign at_zero = (count == '0);

  // An increment that cannot be taken is what the caller treats as a lost event.
  assign sat_hit = inc && !dec && at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && !at_zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/event_blinker.sv
// Stretches single-cycle event strobes into fixed-length blinks separated by a guaranteed gap.
// Optional pending-event queue enabled by defining EVENT_BLINKER_QUEUE_EN.
module event_blinker
  import event_blinker_pkg::*;
#(
  parameter int ON_CLOCK_THR  = DEFAULT_ON_CLOCK_THR,
  parameter int OFF_CLOCK_THR = DEFAULT_OFF_CLOCK_THR,
  parameter int MAX_PENDING   = DEFAULT_MAX_PENDING
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in,
  output logic                               out,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               dropped
);

  localparam int CNT_W  = $clog2(max_int(ON_CLOCK_THR, OFF_CLOCK_THR));
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             on_done;
  logic             gap_done;
  logic             busy_evt;
  logic             have_pending;
  logic             drop_evt;

  assign busy         = (state != ST_IDLE);
  assign on_done      = (state == ST_ON)  && (cnt == CNT_W'(ON_CLOCK_THR - 1));
  assign gap_done     = (state == ST_GAP) && (cnt == CNT_W'(OFF_CLOCK_THR - 1));
  assign have_pending = (pending != '0);

  // The resolving GAP cycle consumes its event directly, so it never queues or drops.
  assign busy_evt = in && busy && !gap_done;

`ifdef EVENT_BLINKER_QUEUE_EN
  logic q_inc;
  logic q_dec;
  logic q_sat;

  assign q_inc = busy_evt;
  assign q_dec = gap_done && !in;

  sat_updown_counter #(
    .MAX_VAL (MAX_PENDING),
    .WIDTH   (PEND_W)
  ) u_pending (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (q_inc),
    .dec     (q_dec),
    .count   (pending),
    .sat_hit (q_sat)
  );

  assign drop_evt = q_sat;
`else
  assign pending  = PEND_W'(0);
  assign drop_evt = busy_evt;
`endif

  // out is the registered image of "next state is ON" so it rises on the sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      out     <= 1'b0;
      dropped <= 1'b0;
    end else begin
      dropped <= drop_evt;
      case (state)
        ST_IDLE: begin
          if (in) begin
            state <= ST_ON;
            cnt   <= '0;
            out   <= 1'b1;
          end
        end
        ST_ON: begin
          if (on_done) begin
            state <= ST_GAP;
            cnt   <= '0;
            out   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            cnt <= '0;
            if (in || have_pending) begin
              state <= ST_ON;
              out   <= 1'b1;
            end else begin
              state <= ST_IDLE;
              out   <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_blinker.sv
// Scoreboard bench for event_blinker with ON=4, OFF=3, MAX_PENDING=2.
// Expectations follow EVENT_BLINKER_QUEUE_EN so the same bench covers both builds.
module tb_event_blinker;

  localparam int ON_THR  = 4;
  localparam int OFF_THR = 3;
  localparam int MAX_PND = 2;

`ifdef EVENT_BLINKER_QUEUE_EN
  localparam bit QEN       = 1'b1;
  localparam int EXP_DROPS = 1;
`else
  localparam bit QEN       = 1'b0;
  localparam int EXP_DROPS = 4;
`endif

  typedef struct {
    int         edge_idx;
    logic       out;
    logic       busy;
    logic [1:0] pending;
    logic       dropped;
    string      tag;
  } snap_t;

  logic       clk;
  logic       rst_n;
  logic       in;
  logic       out;
  logic       busy;
  logic [1:0] pending;
  logic       dropped;

  int    edge_n;
  int    checks;
  int    failures;
  int    drop_seen;
  snap_t exp_q[$];

  event_blinker #(
    .ON_CLOCK_THR  (ON_THR),
    .OFF_CLOCK_THR (OFF_THR),
    .MAX_PENDING   (MAX_PND)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .out     (out),
    .busy    (busy),
    .pending (pending),
    .dropped (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_output(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  task automatic expect_at(input int e, input logic o, input logic b,
                           input logic [1:0] p, input logic d, input string tag);
    snap_t s;
    s.edge_idx = e;
    s.out      = o;
    s.busy     = b;
    s.pending  = p;
    s.dropped  = d;
    s.tag      = tag;
    exp_q.push_back(s);
  endtask

  task automatic apply_stimulus(input int n);
    in = 1'b1;
    repeat (n) @(negedge clk);
    in = 1'b0;
  endtask

  task automatic wait_until_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
    check_output({name, ".queue_left"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, ".out"}, int'(out), 0);
    check_output({name, ".busy"}, int'(busy), 0);
    check_output({name, ".pending"}, int'(pending), 0);
    check_output({name, ".dropped"}, int'(dropped), 0);
  endtask

  // Monitor: pops every expected snapshot whose edge has been reached and compares it.
  always @(negedge clk) begin
    if (dropped) drop_seen++;
    while (exp_q.size() > 0 && exp_q[0].edge_idx <= edge_n) begin
      snap_t s;
      s = exp_q.pop_front();
      if (s.edge_idx < edge_n)
        check_output($sformatf("%s@%0d.stale", s.tag, s.edge_idx), edge_n, s.edge_idx);
      check_output($sformatf("%s@%0d.out", s.tag, s.edge_idx), int'(out), int'(s.out));
      check_output($sformatf("%s@%0d.busy", s.tag, s.edge_idx), int'(busy), int'(s.busy));
      check_output($sformatf("%s@%0d.pending", s.tag, s.edge_idx), int'(pending), int'(s.pending));
      check_output($sformatf("%s@%0d.dropped", s.tag, s.edge_idx), int'(dropped), int'(s.dropped));
    end
  end

  initial begin
    int b;
    int r;
    edge_n    = 0;
    checks    = 0;
    failures  = 0;
    drop_seen = 0;
    in        = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset_state");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single event: ON for 4 edges, GAP for 3, IDLE at b+7.
    @(negedge clk);
    b = edge_n + 1;
    expect_at(b,     1, 1, 0, 0, "single");
    expect_at(b + 3, 1, 1, 0, 0, "single");
    expect_at(b + 4, 0, 1, 0, 0, "single");
    expect_at(b + 6, 0, 1, 0, 0, "single");
    expect_at(b + 7, 0, 0, 0, 0, "single");
    apply_stimulus(1);
    drain("single");

    // Four-cycle burst: first event starts ON, the next three queue or drop.
    @(negedge clk);
    b = edge_n + 1;
    if (QEN) begin
      expect_at(b,      1, 1, 0, 0, "burst");
      expect_at(b + 1,  1, 1, 1, 0, "burst");
      expect_at(b + 2,  1, 1, 2, 0, "burst");
      expect_at(b + 3,  1, 1, 2, 1, "burst");
      expect_at(b + 4,  0, 1, 2, 0, "burst");
      expect_at(b + 6,  0, 1, 2, 0, "burst");
      expect_at(b + 7,  1, 1, 1, 0, "burst");
      expect_at(b + 10, 1, 1, 1, 0, "burst");
      expect_at(b + 11, 0, 1, 1, 0, "burst");
      expect_at(b + 13, 0, 1, 1, 0, "burst");
      expect_at(b + 14, 1, 1, 0, 0, "burst");
      expect_at(b + 17, 1, 1, 0, 0, "burst");
      expect_at(b + 18, 0, 1, 0, 0, "burst");
      expect_at(b + 20, 0, 1, 0, 0, "burst");
      expect_at(b + 21, 0, 0, 0, 0, "burst");
    end else begin
      expect_at(b,      1, 1, 0, 0, "burst");
      expect_at(b + 1,  1, 1, 0, 1, "burst");
      expect_at(b + 2,  1, 1, 0, 1, "burst");
      expect_at(b + 3,  1, 1, 0, 1, "burst");
      expect_at(b + 4,  0, 1, 0, 0, "burst");
      expect_at(b + 6,  0, 1, 0, 0, "burst");
      expect_at(b + 7,  0, 0, 0, 0, "burst");
      expect_at(b + 14, 0, 0, 0, 0, "burst");
      expect_at(b + 21, 0, 0, 0, 0, "burst");
    end
    apply_stimulus(4);
    drain("burst");

    // Event sampled on the resolving GAP edge goes straight back to ON.
    @(negedge clk);
    b = edge_n + 1;
    expect_at(b,      1, 1, 0, 0, "resolve");
    expect_at(b + 3,  1, 1, 0, 0, "resolve");
    expect_at(b + 4,  0, 1, 0, 0, "resolve");
    expect_at(b + 6,  0, 1, 0, 0, "resolve");
    expect_at(b + 7,  1, 1, 0, 0, "resolve");
    expect_at(b + 10, 1, 1, 0, 0, "resolve");
    expect_at(b + 11, 0, 1, 0, 0, "resolve");
    expect_at(b + 13, 0, 1, 0, 0, "resolve");
    expect_at(b + 14, 0, 0, 0, 0, "resolve");
    apply_stimulus(1);
    wait_until_edge(b + 6);
    apply_stimulus(1);
    drain("resolve");

    // Asynchronous reset in the middle of ON with one event queued.
    @(negedge clk);
    b = edge_n + 1;
    expect_at(b,     1, 1, 0, 0, "rst_mid_on");
    expect_at(b + 1, 1, 1, QEN ? 2'd1 : 2'd0, QEN ? 1'b0 : 1'b1, "rst_mid_on");
    apply_stimulus(2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_now");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_all_zero("async_reset_held");
    rst_n = 1'b1;
    r = edge_n;
    expect_at(r + 1, 0, 0, 0, 0, "after_reset");
    expect_at(r + 3, 0, 0, 0, 0, "after_reset");
    expect_at(r + 8, 0, 0, 0, 0, "after_reset");
    drain("after_reset");

    check_output("dropped_pulse_count", drop_seen, EXP_DROPS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
